// File: rtl/ddr_params_pkg.sv
// Shared SDRAM controller constants: bus widths, command encodings and the
// auto-refresh scheduler state encoding.
package ddr_params;

    localparam int DDR_ADDR_WIDTH = 13;
    localparam int DDR_BA_WIDTH   = 2;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PCHA = 3'd1,
        ST_TRP  = 3'd2,
        ST_REF  = 3'd3,
        ST_TRF  = 3'd4,
        ST_END  = 3'd5
    } aref_state_t;

endpackage

// File: rtl/ddr_aref_tick.sv
// Refresh interval counter: held at zero until SDRAM init completes, then
// wraps every CLK_PER_REF cycles and flags the wrap cycle as a tick.
module ddr_aref_tick #(
    parameter int CLK_PER_REF = 1249
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic init_end,
    output logic tick
);

    localparam int              CNT_W    = $clog2(CLK_PER_REF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_REF - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: reset is synchronous, so it lives inside the clocked block as an ordinary branch.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !init_end) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = init_end && (cnt == CNT_LAST);

endmodule

// File: rtl/ddr_ctrl_aref_sched.sv
// Auto-refresh scheduler: accumulates refresh debt from periodic ticks and,
// on arbiter grant, issues PRECHARGE-ALL then a burst of AUTO-REFRESH.
// Define AREF_POSTPONE_EN for a multi-refresh debt counter; otherwise debt
// is a single pending flag and every sequence issues BURST_N refreshes.
module ddr_ctrl_aref_sched
    import ddr_params::*;
#(
    parameter int ADDR_WIDTH  = DDR_ADDR_WIDTH,
    parameter int BA_WIDTH    = DDR_BA_WIDTH,
    parameter int CLK_PER_REF = 1249,
    parameter int TRP_CLK     = 2,
    parameter int TRC_CLK     = 7,
    parameter int BURST_N     = 2,
    parameter int DEBT_MAX    = 8,
    parameter int URGENT_TH   = 6
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  init_end_i,
    input  logic                  aref_en_i,
    input  logic                  aref_ack_i,
    output logic                  aref_req_o,
    output logic                  aref_urgent_o,
    output logic                  aref_busy_o,
    output logic [3:0]            aref_cmd_o,
    output logic [ADDR_WIDTH-1:0] aref_addr_o,
    output logic [BA_WIDTH-1:0]   aref_ba_o,
    output logic                  aref_end_o,
    output logic [3:0]            aref_debt_o,
    output logic                  aref_overflow_o
);

    if (CLK_PER_REF < 16 || TRP_CLK < 2 || TRC_CLK < 2 || BURST_N < 1 || BURST_N > 8 ||
        DEBT_MAX < 1 || DEBT_MAX > 15 || URGENT_TH < 1 || URGENT_TH > DEBT_MAX) begin : g_bad_params
        $error("ddr_ctrl_aref_sched: parameter out of range");
    end

    // Wait counters run TRP_CLK-1 / TRC_CLK-1 cycles; the state hop and the
    // registered command add the remaining cycle of spacing.
    localparam int               WAIT_MAX   = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int               WAIT_W     = $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] TRP_LAST  = WAIT_W'(TRP_CLK - 2);
    localparam logic [WAIT_W-1:0] TRC_LAST  = WAIT_W'(TRC_CLK - 2);
    localparam logic [3:0]        BURST_TOP = 4'(BURST_N);

    aref_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        ref_cnt;
    logic [3:0]        burst_q;
    logic [3:0]        burst_len;
    logic [3:0]        debt;
    logic [3:0]        debt_n;
    logic              ovf;
    logic              ovf_n;
    logic              urgent_n;
    logic              req_n;
    logic              tick;
    logic              ref_now;
    logic              ack_ok;

    ddr_aref_tick #(
        .CLK_PER_REF (CLK_PER_REF)
    ) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .init_end (init_end_i),
        .tick     (tick)
    );

    assign ref_now = (state == ST_REF);
    assign ack_ok  = aref_ack_i && aref_req_o && (state == ST_IDLE);

`ifdef AREF_POSTPONE_EN
    localparam logic [3:0] DEBT_TOP = 4'(DEBT_MAX);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        debt_n = debt;
        ovf_n  = ovf;
        if (tick && !ref_now) begin
            if (debt == DEBT_TOP) ovf_n = 1'b1;
            else                  debt_n = debt + 4'd1;
        end else if (ref_now && !tick) begin
            debt_n = debt - 4'd1;
        end
    end

    assign burst_len = (debt < BURST_TOP) ? debt : BURST_TOP;
    assign urgent_n  = (debt_n >= 4'(URGENT_TH));
`else
    logic clr_now;

    // The pending flag is consumed by the first REF of a sequence.
    assign clr_now = ref_now && (ref_cnt == 4'd0);

    always_comb begin
        debt_n = debt;
        ovf_n  = ovf;
        if (tick && !clr_now) begin
            if (debt[0]) ovf_n = 1'b1;
            else         debt_n = 4'd1;
        end else if (clr_now && !tick) begin
            debt_n = 4'd0;
        end
    end

    assign burst_len = BURST_TOP;
    assign urgent_n  = 1'b0;
`endif

    // Request is built from next-cycle debt so it drops right after a grant
    // and rises in the first IDLE cycle after a sequence.
    assign req_n = (debt_n != 4'd0) && aref_en_i && init_end_i;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            ref_cnt       <= '0;
            burst_q       <= '0;
            debt          <= '0;
            ovf           <= 1'b0;
            aref_req_o    <= 1'b0;
            aref_urgent_o <= 1'b0;
            aref_busy_o   <= 1'b0;
            aref_end_o    <= 1'b0;
            aref_cmd_o    <= CMD_NOP;
        end else begin
            debt          <= debt_n;
            ovf           <= ovf_n;
            aref_urgent_o <= urgent_n;
            aref_end_o    <= (state == ST_END);
            aref_cmd_o    <= (state == ST_PCHA) ? CMD_PRE :
                             (state == ST_REF)  ? CMD_AREF : CMD_NOP;
            aref_req_o    <= 1'b0;
            aref_busy_o   <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (ack_ok) begin
                        state   <= ST_PCHA;
                        burst_q <= burst_len;
                        ref_cnt <= '0;
                    end else begin
                        aref_req_o  <= req_n;
                        aref_busy_o <= 1'b0;
                    end
                end
                ST_PCHA: begin
                    state    <= ST_TRP;
                    wait_cnt <= '0;
                end
                ST_TRP: begin
                    if (wait_cnt == TRP_LAST) state <= ST_REF;
                    else                      wait_cnt <= wait_cnt + 1'b1;
                end
                ST_REF: begin
                    state    <= ST_TRF;
                    ref_cnt  <= ref_cnt + 4'd1;
                    wait_cnt <= '0;
                end
                ST_TRF: begin
                    if (wait_cnt == TRC_LAST) state <= (ref_cnt < burst_q) ? ST_REF : ST_END;
                    else                      wait_cnt <= wait_cnt + 1'b1;
                end
                ST_END: begin
                    state       <= ST_IDLE;
                    aref_req_o  <= req_n;
                    aref_busy_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign aref_addr_o     = '1;
    assign aref_ba_o       = '1;
    assign aref_debt_o     = debt;
    assign aref_overflow_o = ovf;

endmodule

// File: tb/tb_ddr_ctrl_aref_sched.sv
// Directed self-checking bench for ddr_ctrl_aref_sched (CLK_PER_REF=100,
// TRP=2, TRC=6, BURST_N=2); follows AREF_POSTPONE_EN like the design.
module tb_ddr_ctrl_aref_sched;

    localparam int CPR = 100;
    localparam int TRP = 2;
    localparam int TRC = 6;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
`ifdef AREF_POSTPONE_EN
    localparam int N_FIRST = 1;
    int drain_n [5] = '{2, 2, 2, 2, 1};
`else
    localparam int N_FIRST = 2;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end_i;
    logic        aref_en_i;
    logic        aref_ack_i;
    logic        aref_req_o;
    logic        aref_urgent_o;
    logic        aref_busy_o;
    logic [3:0]  aref_cmd_o;
    logic [12:0] aref_addr_o;
    logic [1:0]  aref_ba_o;
    logic        aref_end_o;
    logic [3:0]  aref_debt_o;
    logic        aref_overflow_o;

    int cyc = 0;
    int t0;
    int n_tests = 0;
    int n_fail  = 0;
    int first_aref_debt;

    ddr_ctrl_aref_sched #(
        .ADDR_WIDTH  (13),
        .BA_WIDTH    (2),
        .CLK_PER_REF (CPR),
        .TRP_CLK     (TRP),
        .TRC_CLK     (TRC),
        .BURST_N     (2),
        .DEBT_MAX    (8),
        .URGENT_TH   (6)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .init_end_i      (init_end_i),
        .aref_en_i       (aref_en_i),
        .aref_ack_i      (aref_ack_i),
        .aref_req_o      (aref_req_o),
        .aref_urgent_o   (aref_urgent_o),
        .aref_busy_o     (aref_busy_o),
        .aref_cmd_o      (aref_cmd_o),
        .aref_addr_o     (aref_addr_o),
        .aref_ba_o       (aref_ba_o),
        .aref_end_o      (aref_end_o),
        .aref_debt_o     (aref_debt_o),
        .aref_overflow_o (aref_overflow_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst    = 1'b1;
        init_end_i = 1'b0;
        aref_en_i  = 1'b0;
        aref_ack_i = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic release_reset(input logic enable);
        sys_rst    = 1'b0;
        init_end_i = 1'b1;
        aref_en_i  = enable;
        t0         = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic wait_req(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !aref_req_o; i++) @(negedge sys_clk);
        check({tag, "_req_seen"}, aref_req_o, 1'b1);
    endtask

    // Grants the pending request and checks the whole PRE/AREF/END timeline.
    task automatic grant_and_check(input string tag, input int exp_n);
        int ack_t;
        int pre_t;
        int end_t;
        int last_t;
        int n_aref;
        pre_t  = -1;
        end_t  = -1;
        last_t = -1;
        n_aref = 0;
        ack_t  = cyc;
        aref_ack_i = 1'b1;
        @(negedge sys_clk);
        aref_ack_i = 1'b0;
        check({tag, "_req_low"}, aref_req_o, 1'b0);
        check({tag, "_busy"}, aref_busy_o, 1'b1);
        for (int i = 0; i < 100 && end_t < 0; i++) begin
            if (aref_cmd_o == PRE && pre_t < 0) pre_t = cyc;
            if (aref_cmd_o == AREF) begin
                if (n_aref == 0) begin
                    check({tag, "_pre_to_aref"}, cyc - pre_t, TRP);
                    first_aref_debt = aref_debt_o;
                end else begin
                    check({tag, "_aref_gap"}, cyc - last_t, TRC);
                end
                last_t = cyc;
                n_aref++;
            end
            if (aref_end_o) end_t = cyc;
            else            @(negedge sys_clk);
        end
        check({tag, "_pre_lat"}, pre_t - ack_t, 2);
        check({tag, "_n_aref"}, n_aref, exp_n);
        check({tag, "_end_gap"}, end_t - last_t, TRC);
        @(negedge sys_clk);
        check({tag, "_end_width"}, aref_end_o, 1'b0);
        check({tag, "_idle"}, aref_busy_o, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_late;
        sys_rst    = 1'b1;
        init_end_i = 1'b0;
        aref_en_i  = 1'b0;
        aref_ack_i = 1'b0;

        do_reset();
        check("rst_cmd", aref_cmd_o, NOP);
        check("rst_addr", aref_addr_o, 13'h1FFF);
        check("rst_ba", aref_ba_o, 2'b11);
        check("rst_req", aref_req_o, 1'b0);
        check("rst_urgent", aref_urgent_o, 1'b0);
        check("rst_busy", aref_busy_o, 1'b0);
        check("rst_end", aref_end_o, 1'b0);
        check("rst_debt", aref_debt_o, 4'd0);
        check("rst_ovf", aref_overflow_o, 1'b0);

        // First tick and a single granted sequence.
        release_reset(1'b1);
        wait_req("t1", 150);
        check("t1_req_lat", cyc - t0, CPR);
        check("t1_debt", aref_debt_o, 4'd1);
        grant_and_check("t1", N_FIRST);
        check("t1_debt_clear", aref_debt_o, 4'd0);
        check("t1_urgent", aref_urgent_o, 1'b0);

`ifdef AREF_POSTPONE_EN
        // Postponed refreshes accumulate to the urgent level.
        aref_en_i = 1'b0;
        repeat (650) @(negedge sys_clk);
        check("t2_debt6", aref_debt_o, 4'd6);
        check("t2_urgent", aref_urgent_o, 1'b1);
        check("t2_req_off", aref_req_o, 1'b0);
        aref_en_i = 1'b1;
        wait_req("t2", 5);
        grant_and_check("t2", 2);
        check("t2_debt4", aref_debt_o, 4'd4);
        check("t2_urgent_off", aref_urgent_o, 1'b0);
        check("t2_req_again", aref_req_o, 1'b1);

        // Saturation, overflow stickiness and full drain.
        do_reset();
        release_reset(1'b0);
        wait_until(t0 + 550);
        check("t3_debt5", aref_debt_o, 4'd5);
        check("t3_urgent5", aref_urgent_o, 1'b0);
        wait_until(t0 + 650);
        check("t3_urgent6", aref_urgent_o, 1'b1);
        wait_until(t0 + 850);
        check("t3_debt8", aref_debt_o, 4'd8);
        check("t3_ovf_before", aref_overflow_o, 1'b0);
        wait_until(t0 + 950);
        check("t3_debt_sat", aref_debt_o, 4'd8);
        check("t3_ovf", aref_overflow_o, 1'b1);
        aref_en_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_req("t3_drain", 20);
            grant_and_check("t3_drain", drain_n[k]);
        end
        check("t3_drained", aref_debt_o, 4'd0);
        check("t3_ovf_sticky", aref_overflow_o, 1'b1);
`else
        // Second tick while the flag is pending overflows.
        aref_en_i = 1'b0;
        wait_until(t0 + 250);
        check("t6_flag", aref_debt_o, 4'd1);
        check("t6_ovf_before", aref_overflow_o, 1'b0);
        wait_until(t0 + 350);
        check("t6_flag_hold", aref_debt_o, 4'd1);
        check("t6_ovf", aref_overflow_o, 1'b1);
        check("t6_urgent", aref_urgent_o, 1'b0);
        aref_en_i = 1'b1;
        wait_req("t6", 5);
        grant_and_check("t6", 2);
        check("t6_flag_clear", aref_debt_o, 4'd0);
        check("t6_ovf_sticky", aref_overflow_o, 1'b1);
`endif

        // Tick lands in the same cycle as the first REF state.
        do_reset();
        release_reset(1'b0);
        wait_until(t0 + 195);
        aref_en_i = 1'b1;
        @(negedge sys_clk);
        check("t4_req", aref_req_o, 1'b1);
        grant_and_check("t4", N_FIRST);
        check("t4_debt_at_aref", first_aref_debt, 1);
        check("t4_debt_after", aref_debt_o, 4'd1);
        wait_req("t4b", 20);
        grant_and_check("t4b", N_FIRST);
        check("t4_drained", aref_debt_o, 4'd0);

        // Reset while waiting out tRC after the first AREF.
        do_reset();
        release_reset(1'b0);
        wait_until(t0 + 250);
        aref_en_i = 1'b1;
        wait_req("t5", 5);
        aref_ack_i = 1'b1;
        @(negedge sys_clk);
        aref_ack_i = 1'b0;
        for (int i = 0; i < 20 && aref_cmd_o !== AREF; i++) @(negedge sys_clk);
        check("t5_aref_seen", aref_cmd_o, AREF);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t5_cmd", aref_cmd_o, NOP);
        check("t5_busy", aref_busy_o, 1'b0);
        check("t5_debt", aref_debt_o, 4'd0);
        check("t5_req", aref_req_o, 1'b0);
        check("t5_ovf", aref_overflow_o, 1'b0);
        sys_rst = 1'b0;
        n_late  = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (aref_cmd_o == AREF || aref_end_o) n_late++;
        end
        check("t5_no_aref", n_late, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
